// File: rtl/mshr_chi_sched.sv
// MSHR-to-CHI scheduler: round-robin issue of pending misses through a one-entry request slot,
// outstanding-id tracking, response routing, and an independent round-robin refill arbiter.
module mshr_chi_sched #(
  parameter int MSHR_NUM     = 8,
  parameter int MSHR_NUM_LOG = 3,
  parameter int PADDR_W      = 48
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MSHR_NUM-1:0]         req_valid_vec,
  input  logic [MSHR_NUM*PADDR_W-1:0] req_paddr_flat,
  output logic [MSHR_NUM-1:0]         win_chi_arb,
  output logic                        dmshr2chi_valid,
  input  logic                        dmshr2chi_ready,
  output logic [PADDR_W-1:0]          dmshr2chi_paddr,
  output logic [MSHR_NUM_LOG-1:0]     dmshr2chi_mshrid,
  input  logic                        chi_resp_valid,
  input  logic [MSHR_NUM_LOG-1:0]     chi_resp_mshrid,
  input  logic [511:0]                chi_resp_data,
  output logic [MSHR_NUM-1:0]         chi_arb_resp_valid,
  output logic [511:0]                chi_arb_resp_data,
  input  logic [MSHR_NUM-1:0]         rdy2refill_vec,
  input  logic                        refill_ready,
  output logic [MSHR_NUM-1:0]         win_refill_arb,
  output logic [MSHR_NUM-1:0]         outstanding_vec,
  output logic                        resp_err
);

  logic                    r_valid;
  logic [PADDR_W-1:0]      r_paddr;
  logic [MSHR_NUM_LOG-1:0] r_mshrid;
  logic [MSHR_NUM_LOG-1:0] r_chi_ptr;
  logic [MSHR_NUM_LOG-1:0] r_refill_ptr;
  logic [MSHR_NUM-1:0]     r_outstanding;
  logic [MSHR_NUM-1:0]     r_resp_valid;
  logic [511:0]            r_resp_data;
  logic                    r_resp_err;

  logic [PADDR_W-1:0]      w_paddr_arr [MSHR_NUM];
  logic                    w_hs;
  logic                    w_load;
  logic [MSHR_NUM-1:0]     w_inflight_oh;
  logic [MSHR_NUM-1:0]     w_cand;
  logic [MSHR_NUM-1:0]     w_issue_set;
  logic [MSHR_NUM-1:0]     w_resp_clr;
  logic                    w_resp_hit;
  logic [MSHR_NUM_LOG-1:0] w_ptr_eff;
  logic [MSHR_NUM_LOG-1:0] w_cidx;
  logic [MSHR_NUM_LOG-1:0] w_pick_id;
  logic                    w_found;
  logic [MSHR_NUM_LOG-1:0] w_ridx;
  logic [MSHR_NUM_LOG-1:0] w_refill_id;
  logic                    w_rfound;
  logic                    w_refill_grant;

  for (genvar g = 0; g < MSHR_NUM; g++) begin : g_unpack
    assign w_paddr_arr[g] = req_paddr_flat[g*PADDR_W +: PADDR_W];
  end

  // Request port: a beat transfers when valid & ready are both high on a rising edge; once valid
  // rises, valid/paddr/mshrid stay fixed until that transfer, and a new beat may load the same cycle.
  assign w_hs          = r_valid & dmshr2chi_ready;
  assign w_load        = ~r_valid | w_hs;
  assign w_inflight_oh = r_valid ? (MSHR_NUM'(1) << r_mshrid) : '0;
  assign w_cand        = req_valid_vec & ~r_outstanding & ~w_inflight_oh;
  assign w_issue_set   = w_hs ? w_inflight_oh : '0;
  assign w_resp_clr    = chi_resp_valid ? (MSHR_NUM'(1) << chi_resp_mshrid) : '0;
  assign w_resp_hit    = chi_resp_valid & r_outstanding[chi_resp_mshrid];
  // A back-to-back load already sees the pointer advanced past the entry leaving the slot.
  assign w_ptr_eff     = w_hs ? (r_mshrid + MSHR_NUM_LOG'(1)) : r_chi_ptr;

  always_comb begin
    w_found   = 1'b0;
    w_pick_id = '0;
    w_cidx    = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      w_cidx = w_ptr_eff + MSHR_NUM_LOG'(i);
      if (!w_found && w_cand[w_cidx]) begin
        w_found   = 1'b1;
        w_pick_id = w_cidx;
      end
    end
  end

  always_comb begin
    w_rfound    = 1'b0;
    w_refill_id = '0;
    w_ridx      = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      w_ridx = r_refill_ptr + MSHR_NUM_LOG'(i);
      if (!w_rfound && rdy2refill_vec[w_ridx]) begin
        w_rfound    = 1'b1;
        w_refill_id = w_ridx;
      end
    end
  end

  assign w_refill_grant = w_rfound & refill_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_paddr       <= '0;
      r_mshrid      <= '0;
      r_chi_ptr     <= '0;
      r_refill_ptr  <= '0;
      r_outstanding <= '0;
      r_resp_valid  <= '0;
      r_resp_data   <= '0;
      r_resp_err    <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_found;
        if (w_found) begin
          r_paddr  <= {w_paddr_arr[w_pick_id][PADDR_W-1:6], 6'b0};
          r_mshrid <= w_pick_id;
        end
      end
      if (w_hs) r_chi_ptr <= r_mshrid + MSHR_NUM_LOG'(1);
      // Clear first, then set: a same-cycle issue of the responding id stays outstanding.
      r_outstanding <= (r_outstanding & ~w_resp_clr) | w_issue_set;
      r_resp_valid  <= w_resp_hit ? w_resp_clr : '0;
      if (chi_resp_valid) r_resp_data <= chi_resp_data;
      if (chi_resp_valid && !w_resp_hit) r_resp_err <= 1'b1;
      if (w_refill_grant) r_refill_ptr <= w_refill_id + MSHR_NUM_LOG'(1);
    end
  end

  assign win_chi_arb        = w_issue_set;
  assign dmshr2chi_valid    = r_valid;
  assign dmshr2chi_paddr    = r_paddr;
  assign dmshr2chi_mshrid   = r_mshrid;
  assign chi_arb_resp_valid = r_resp_valid;
  assign chi_arb_resp_data  = r_resp_data;
  assign win_refill_arb     = w_refill_grant ? (MSHR_NUM'(1) << w_refill_id) : '0;
  assign outstanding_vec    = r_outstanding;
  assign resp_err           = r_resp_err;

endmodule

// File: tb/tb_mshr_chi_sched.sv
// Bench for mshr_chi_sched: directed scenario tasks plus a randomized run checked against
// an array/queue based reference model of the scheduling rules.
module tb_mshr_chi_sched;
  localparam int N  = 8;
  localparam int LG = 3;
  localparam int PW = 48;

  logic             clock = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid_vec;
  logic [N*PW-1:0]  req_paddr_flat;
  logic [PW-1:0]    tb_paddr [N];
  logic [N-1:0]     win_chi_arb;
  logic             dmshr2chi_valid;
  logic             dmshr2chi_ready;
  logic [PW-1:0]    dmshr2chi_paddr;
  logic [LG-1:0]    dmshr2chi_mshrid;
  logic             chi_resp_valid;
  logic [LG-1:0]    chi_resp_mshrid;
  logic [511:0]     chi_resp_data;
  logic [N-1:0]     chi_arb_resp_valid;
  logic [511:0]     chi_arb_resp_data;
  logic [N-1:0]     rdy2refill_vec;
  logic             refill_ready;
  logic [N-1:0]     win_refill_arb;
  logic [N-1:0]     outstanding_vec;
  logic             resp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_paddr_flat[g*PW +: PW] = tb_paddr[g];
  end

  mshr_chi_sched #(.MSHR_NUM(N), .MSHR_NUM_LOG(LG), .PADDR_W(PW)) dut (
    .clock(clock), .reset(reset),
    .req_valid_vec(req_valid_vec), .req_paddr_flat(req_paddr_flat),
    .win_chi_arb(win_chi_arb),
    .dmshr2chi_valid(dmshr2chi_valid), .dmshr2chi_ready(dmshr2chi_ready),
    .dmshr2chi_paddr(dmshr2chi_paddr), .dmshr2chi_mshrid(dmshr2chi_mshrid),
    .chi_resp_valid(chi_resp_valid), .chi_resp_mshrid(chi_resp_mshrid),
    .chi_resp_data(chi_resp_data),
    .chi_arb_resp_valid(chi_arb_resp_valid), .chi_arb_resp_data(chi_arb_resp_data),
    .rdy2refill_vec(rdy2refill_vec), .refill_ready(refill_ready),
    .win_refill_arb(win_refill_arb), .outstanding_vec(outstanding_vec),
    .resp_err(resp_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid_vec   = '0;
    dmshr2chi_ready = 1'b0;
    chi_resp_valid  = 1'b0;
    chi_resp_mshrid = '0;
    chi_resp_data   = '0;
    rdy2refill_vec  = '0;
    refill_ready    = 1'b0;
    for (int i = 0; i < N; i++) tb_paddr[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", dmshr2chi_valid); end
    tests_run++; if (dmshr2chi_paddr !== '0) begin tests_failed++; $display("FAIL reset_paddr: got %h want 0", dmshr2chi_paddr); end
    tests_run++; if (dmshr2chi_mshrid !== '0) begin tests_failed++; $display("FAIL reset_mshrid: got %0d want 0", dmshr2chi_mshrid); end
    tests_run++; if (win_chi_arb !== '0) begin tests_failed++; $display("FAIL reset_win_chi: got %h want 0", win_chi_arb); end
    tests_run++; if (chi_arb_resp_valid !== '0) begin tests_failed++; $display("FAIL reset_resp_valid: got %h want 0", chi_arb_resp_valid); end
    tests_run++; if (chi_arb_resp_data !== '0) begin tests_failed++; $display("FAIL reset_resp_data: got nonzero want 0"); end
    tests_run++; if (win_refill_arb !== '0) begin tests_failed++; $display("FAIL reset_win_refill: got %h want 0", win_refill_arb); end
    tests_run++; if (outstanding_vec !== '0) begin tests_failed++; $display("FAIL reset_outstanding: got %h want 0", outstanding_vec); end
    tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_err: got %0b want 0", resp_err); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_issue();
    do_reset();
    tb_paddr[0]     = 48'h0000_1000_0047;
    req_valid_vec   = 8'h01;
    dmshr2chi_ready = 1'b1;
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b0) begin tests_failed++; $display("FAIL issue_latency: valid got %0b want 0", dmshr2chi_valid); end
    tick();
    req_valid_vec = 8'h00;
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b1) begin tests_failed++; $display("FAIL issue_valid: got %0b want 1", dmshr2chi_valid); end
    tests_run++; if (dmshr2chi_paddr !== 48'h0000_1000_0040) begin tests_failed++; $display("FAIL issue_paddr: got %h want 000010000040", dmshr2chi_paddr); end
    tests_run++; if (dmshr2chi_mshrid !== 3'd0) begin tests_failed++; $display("FAIL issue_mshrid: got %0d want 0", dmshr2chi_mshrid); end
    tests_run++; if (win_chi_arb !== 8'h01) begin tests_failed++; $display("FAIL issue_win: got %h want 01", win_chi_arb); end
    tick();
    @(negedge clock);
    tests_run++; if (outstanding_vec !== 8'h01) begin tests_failed++; $display("FAIL issue_outstanding: got %h want 01", outstanding_vec); end
    tests_run++; if (dmshr2chi_valid !== 1'b0) begin tests_failed++; $display("FAIL issue_slot_empty: got %0b want 0", dmshr2chi_valid); end
  endtask

  task automatic test_rr_order();
    int q[$];
    logic [N-1:0] drop;
    do_reset();
    req_valid_vec   = 8'h29;
    dmshr2chi_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      drop = win_chi_arb;
      if (win_chi_arb != '0) q.push_back(int'(dmshr2chi_mshrid));
      tick();
      req_valid_vec = req_valid_vec & ~drop;
    end
    tests_run++; if (q.size() != 3) begin tests_failed++; $display("FAIL rr_count: got %0d issues want 3", q.size()); end
    tests_run++; if (q.size() != 3 || q[0] != 0 || q[1] != 3 || q[2] != 5) begin tests_failed++; $display("FAIL rr_order: got %p want 0,3,5", q); end
    tests_run++; if (outstanding_vec !== 8'h29) begin tests_failed++; $display("FAIL rr_outstanding: got %h want 29", outstanding_vec); end
    chi_resp_valid  = 1'b1;
    chi_resp_mshrid = 3'd0;
    tick();
    chi_resp_valid = 1'b0;
    req_valid_vec  = 8'h07;
    tick();
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b1 || dmshr2chi_mshrid !== 3'd0) begin tests_failed++; $display("FAIL rr_wrap: got valid %0b id %0d want 1 id 0", dmshr2chi_valid, dmshr2chi_mshrid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tb_paddr[2]     = 48'hABCD_0000_1234;
    tb_paddr[1]     = 48'h5555_0000_0080;
    dmshr2chi_ready = 1'b0;
    req_valid_vec   = 8'h04;
    tick();
    req_valid_vec = 8'h06;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      tests_run++; if (dmshr2chi_valid !== 1'b1 || dmshr2chi_mshrid !== 3'd2 || dmshr2chi_paddr !== 48'hABCD_0000_1200 || win_chi_arb !== '0) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got v%0b id%0d pa %h win %h want v1 id2 pa abcd00001200 win 00", c, dmshr2chi_valid, dmshr2chi_mshrid, dmshr2chi_paddr, win_chi_arb);
      end
      tick();
    end
    dmshr2chi_ready = 1'b1;
    @(negedge clock);
    tests_run++; if (win_chi_arb !== 8'h04) begin tests_failed++; $display("FAIL bp_release_win: got %h want 04", win_chi_arb); end
    tick();
    req_valid_vec = 8'h02;
    @(negedge clock);
    tests_run++; if (dmshr2chi_mshrid !== 3'd1 || dmshr2chi_paddr !== 48'h5555_0000_0080 || win_chi_arb !== 8'h02) begin
      tests_failed++; $display("FAIL bp_next: got id%0d pa %h win %h want id1 pa 555500000080 win 02", dmshr2chi_mshrid, dmshr2chi_paddr, win_chi_arb);
    end
  endtask

  task automatic test_response();
    do_reset();
    tb_paddr[3]     = 48'h0000_0000_3000;
    req_valid_vec   = 8'h08;
    dmshr2chi_ready = 1'b1;
    tick();
    req_valid_vec = 8'h00;
    tick();
    @(negedge clock);
    tests_run++; if (outstanding_vec !== 8'h08) begin tests_failed++; $display("FAIL resp_pre_outstanding: got %h want 08", outstanding_vec); end
    tick();
    chi_resp_valid  = 1'b1;
    chi_resp_mshrid = 3'd3;
    chi_resp_data   = {64{8'hA5}};
    tick();
    chi_resp_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (chi_arb_resp_valid !== 8'h08) begin tests_failed++; $display("FAIL resp_strobe: got %h want 08", chi_arb_resp_valid); end
    tests_run++; if (chi_arb_resp_data !== {64{8'hA5}}) begin tests_failed++; $display("FAIL resp_data: got %h want a5 pattern", chi_arb_resp_data[63:0]); end
    tests_run++; if (outstanding_vec !== 8'h00) begin tests_failed++; $display("FAIL resp_clear: got %h want 00", outstanding_vec); end
    tests_run++; if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL resp_err_clean: got %0b want 0", resp_err); end
    tick();
    chi_resp_valid  = 1'b1;
    chi_resp_mshrid = 3'd6;
    tick();
    chi_resp_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (chi_arb_resp_valid !== 8'h00) begin tests_failed++; $display("FAIL resp_bad_strobe: got %h want 00", chi_arb_resp_valid); end
    tests_run++; if (resp_err !== 1'b1) begin tests_failed++; $display("FAIL resp_err_set: got %0b want 1", resp_err); end
    tick();
    tick();
    @(negedge clock);
    tests_run++; if (resp_err !== 1'b1) begin tests_failed++; $display("FAIL resp_err_sticky: got %0b want 1", resp_err); end
  endtask

  task automatic test_refill();
    logic         rr  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] exp [8] = '{8'h01, 8'h80, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80};
    do_reset();
    rdy2refill_vec = 8'h81;
    for (int c = 0; c < 8; c++) begin
      refill_ready = rr[c];
      @(negedge clock);
      tests_run++; if (win_refill_arb !== exp[c]) begin tests_failed++; $display("FAIL refill[%0d]: got %h want %h", c, win_refill_arb, exp[c]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tb_paddr[4]     = 48'h0000_0000_4400;
    req_valid_vec   = 8'h06;
    dmshr2chi_ready = 1'b1;
    tick();
    tick();
    tick();
    req_valid_vec   = 8'h10;
    dmshr2chi_ready = 1'b0;
    tick();
    @(negedge clock);
    tests_run++; if (dmshr2chi_mshrid !== 3'd4 || outstanding_vec !== 8'h06) begin tests_failed++; $display("FAIL mid_setup: got id%0d out %h want id4 out 06", dmshr2chi_mshrid, outstanding_vec); end
    tick();
    reset         = 1'b1;
    req_valid_vec = 8'h00;
    tick();
    reset           = 1'b0;
    req_valid_vec   = 8'h12;
    dmshr2chi_ready = 1'b1;
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b0 || dmshr2chi_paddr !== '0 || dmshr2chi_mshrid !== '0 || win_chi_arb !== '0) begin
      tests_failed++; $display("FAIL mid_reset_slot: got v%0b pa %h id%0d win %h want all 0", dmshr2chi_valid, dmshr2chi_paddr, dmshr2chi_mshrid, win_chi_arb);
    end
    tests_run++; if (outstanding_vec !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_outstanding: got %h want 00", outstanding_vec); end
    tick();
    @(negedge clock);
    tests_run++; if (dmshr2chi_valid !== 1'b1 || dmshr2chi_mshrid !== 3'd1) begin tests_failed++; $display("FAIL mid_post_ptr: got v%0b id%0d want v1 id1", dmshr2chi_valid, dmshr2chi_mshrid); end
  endtask

  // Randomized run against a reference model of the scheduling rules.
  task automatic test_random();
    bit           m_valid;
    int           m_id;
    logic [PW-1:0] m_paddr;
    int           m_ptr;
    int           m_rptr;
    bit           m_out [N];
    bit           m_err;
    logic [N-1:0] m_resp;
    logic [511:0] m_rdata;
    logic [N-1:0] drop;
    logic [N-1:0] exp_win;
    logic [N-1:0] exp_rwin;
    logic [N-1:0] exp_out;
    int           rwin_id;
    int           outs[$];
    logic [511:0] d;
    do_reset();
    m_valid = 0; m_id = 0; m_paddr = '0; m_ptr = 0; m_rptr = 0; m_err = 0;
    m_resp = '0; m_rdata = '0; drop = '0;
    for (int i = 0; i < N; i++) m_out[i] = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (drop[i]) req_valid_vec[i] = 1'b0;
        else if (!req_valid_vec[i] && !m_out[i] && !(m_valid && m_id == i) && $urandom_range(0, 3) == 0) begin
          req_valid_vec[i] = 1'b1;
          tb_paddr[i] = PW'({$urandom(), $urandom()});
        end
      end
      dmshr2chi_ready = ($urandom_range(0, 2) != 0);
      chi_resp_valid  = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        outs.delete();
        for (int i = 0; i < N; i++) if (m_out[i]) outs.push_back(i);
        if (outs.size() > 0 && $urandom_range(0, 15) != 0) chi_resp_mshrid = LG'(outs[$urandom_range(0, outs.size() - 1)]);
        else chi_resp_mshrid = LG'($urandom_range(0, N - 1));
        d = '0;
        for (int k = 0; k < 16; k++) d = {d[479:0], $urandom()};
        chi_resp_data  = d;
        chi_resp_valid = 1'b1;
      end
      rdy2refill_vec = N'($urandom_range(0, 255));
      refill_ready   = 1'(($urandom_range(0, 1)));

      @(negedge clock);
      exp_win = (m_valid && dmshr2chi_ready) ? (N'(1) << m_id) : '0;
      exp_rwin = '0;
      rwin_id = -1;
      if (refill_ready) begin
        for (int i = 0; i < N; i++) begin
          if (rwin_id < 0 && rdy2refill_vec[(m_rptr + i) % N]) rwin_id = (m_rptr + i) % N;
        end
        if (rwin_id >= 0) exp_rwin = N'(1) << rwin_id;
      end
      for (int i = 0; i < N; i++) exp_out[i] = m_out[i];
      tests_run++; if (win_chi_arb !== exp_win) begin tests_failed++; $display("FAIL rnd_win_chi@%0d: got %h want %h", cyc, win_chi_arb, exp_win); end
      tests_run++; if (win_refill_arb !== exp_rwin) begin tests_failed++; $display("FAIL rnd_win_refill@%0d: got %h want %h", cyc, win_refill_arb, exp_rwin); end
      tests_run++; if (dmshr2chi_valid !== m_valid) begin tests_failed++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, dmshr2chi_valid, m_valid); end
      if (m_valid) begin
        tests_run++; if (dmshr2chi_mshrid !== LG'(m_id) || dmshr2chi_paddr !== m_paddr) begin tests_failed++; $display("FAIL rnd_slot@%0d: got id%0d pa %h want id%0d pa %h", cyc, dmshr2chi_mshrid, dmshr2chi_paddr, m_id, m_paddr); end
      end
      tests_run++; if (outstanding_vec !== exp_out) begin tests_failed++; $display("FAIL rnd_outstanding@%0d: got %h want %h", cyc, outstanding_vec, exp_out); end
      tests_run++; if (chi_arb_resp_valid !== m_resp) begin tests_failed++; $display("FAIL rnd_resp_valid@%0d: got %h want %h", cyc, chi_arb_resp_valid, m_resp); end
      if (m_resp != '0) begin
        tests_run++; if (chi_arb_resp_data !== m_rdata) begin tests_failed++; $display("FAIL rnd_resp_data@%0d: got %h want %h", cyc, chi_arb_resp_data[63:0], m_rdata[63:0]); end
      end
      tests_run++; if (resp_err !== m_err) begin tests_failed++; $display("FAIL rnd_resp_err@%0d: got %0b want %0b", cyc, resp_err, m_err); end

      // advance the model across the coming clock edge
      begin
        bit hs;
        int old_id;
        int ptr_eff;
        int nid;
        hs      = m_valid && dmshr2chi_ready;
        old_id  = m_id;
        ptr_eff = hs ? (m_id + 1) % N : m_ptr;
        if (hs) m_ptr = ptr_eff;
        if (!m_valid || hs) begin
          nid = -1;
          for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr_eff + i) % N;
            if (nid < 0 && req_valid_vec[j] && !m_out[j] && !(m_valid && j == old_id)) nid = j;
          end
          m_valid = (nid >= 0);
          if (nid >= 0) begin
            m_id    = nid;
            m_paddr = tb_paddr[nid] & ~PW'(63);
          end
        end
        m_resp = '0;
        if (chi_resp_valid) begin
          if (m_out[chi_resp_mshrid]) m_resp = N'(1) << chi_resp_mshrid;
          else m_err = 1;
          m_rdata = chi_resp_data;
          m_out[chi_resp_mshrid] = 0;
        end
        if (hs) m_out[old_id] = 1;
        if (rwin_id >= 0) m_rptr = (rwin_id + 1) % N;
      end
      drop = exp_win;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_issue();
    test_rr_order();
    test_backpressure();
    test_response();
    test_refill();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
